cmd_arbiter: RTL and testbench
==============================

CMD_ARBITER -- requirements
Module: cmd_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, sets the cycles allowed in WAIT_RESP before timeout, range 2..65535.
REQ-002 Parameter ERROR_INDEX, default 12, is the command index flagged as an index error.
REQ-003 Port list, one per line, name  direction  width  meaning; clock and reset come first; all outputs are registered:
 clk_host  in  1  the only clock.
 reset_host  in  1  asynchronous, active-low reset.
 req_host / req_auto  in  1  level requests; held until the matching done pulse.
 host_index / auto_index  in  6  command index.
 host_argument / auto_argument  in  32  command argument.
 grant_host / grant_auto  out  1  one-hot; high from grant until done.
 done_host / done_auto  out  1  1-cycle completion pulse.
 resp_out  out  128  response payload, phy_response[135:8].
 index_error  out  1  granted index equals ERROR_INDEX.
 timeout_error  out  1  no response within TIMEOUT_CYCLES.
 busy  out  1  state is not IDLE.
 phy_strobe  out  1  command valid to the physical layer.
 phy_cmd  out  40  frame {1'b0, 1'b1, index[5:0], argument[31:0]}.
 phy_resp_strobe  in  1  response valid from the physical layer.
 phy_response  in  136  raw response.
 phy_ack  out  1  response accepted.
 phy_ack_in  in  1  physical layer saw phy_ack.

Function
REQ-004 States: IDLE, ISSUE, WAIT_RESP, ACK, DONE.
REQ-005 IDLE transition: if any request is high at an edge, go to ISSUE at that edge; otherwise stay in IDLE.
REQ-006 IDLE grant load: the same edge asserts one grant, loads phy_cmd from the winner's index/argument, and sets index_error to (index==ERROR_INDEX).
REQ-007 Tie-break is round-robin: when both requests are high, grant the requester not served last.
REQ-008 The last-served flag resets to "auto", so the first tie goes to host.
REQ-009 ISSUE: drive phy_strobe=1 and go to WAIT_RESP on the next edge; phy_strobe stays 1 through WAIT_RESP.
REQ-010 WAIT_RESP, response arrives: when phy_resp_strobe=1, capture resp_out<=phy_response[135:8], drop phy_strobe, and go to ACK.
REQ-011 WAIT_RESP, timeout: the counter increments each cycle in WAIT_RESP; when it reaches TIMEOUT_CYCLES-1 with no response, set timeout_error=1, clear resp_out to 0, drop phy_strobe, and go to DONE.
REQ-012 If phy_resp_strobe=1 on the same cycle the counter reaches TIMEOUT_CYCLES-1, the response wins and timeout_error stays 0.
REQ-013 ACK: drive phy_ack=1 until phy_ack_in=1, then drop phy_ack and go to DONE.
REQ-014 DONE, one cycle: pulse done of the granted requester, clear its grant, update the last-served flag, and return to IDLE.
REQ-015 A new grant is issued no earlier than the edge after DONE, so there is at least one idle cycle between commands.
REQ-016 Timeout counter: it clears on entry to ISSUE and is 16 bits wide, saturating.
REQ-017 phy_cmd, resp_out, index_error and timeout_error hold their values until the next grant.
REQ-018 timeout_error clears at the next grant.
REQ-019 A request dropped mid-transaction does not abort it; the command completes and done still pulses.
REQ-020 Changes to index/argument after grant are ignored.
REQ-021 phy_resp_strobe outside WAIT_RESP is ignored.
REQ-022 phy_ack_in outside ACK is ignored.

Reset
REQ-023 While reset_host=0: state=IDLE, every output=0, counter=0, last-served="auto".
REQ-024 Reset asserted mid-transaction aborts immediately; no done pulse is issued.
REQ-025 The first grant occurs no earlier than the first rising edge after reset_host deasserts.

Structure
REQ-026 Shared package cmd_pkg holds the state enumeration, the frame start bits 2'b01, the default ERROR_INDEX, and the frame/response widths 40/136/128.
REQ-027 One sub-module, cmd_timeout_counter: clear, enable, terminal-count output.
REQ-028 Arbitration logic and the FSM live in cmd_arbiter.

Verification
REQ-029 Host-only command: req_host, index 3, argument 32'h0000_0001; respond after 5 cycles with phy_response[135:8]=128'hA5...A5; ack after 2 cycles -> phy_cmd=40'h43_0000_0001, resp_out=A5..A5, one done_host pulse, index_error=0.
REQ-030 Tie: req_host and req_auto rise on the same cycle -> host served first, then auto; a second tie after that -> host again (alternation); grants are never both high.
REQ-031 Timeout: TIMEOUT_CYCLES=64 with no phy_resp_strobe -> timeout_error=1 and done pulses exactly 64 cycles after entry to WAIT_RESP; resp_out=0; phy_ack is never asserted.
REQ-032 Index error: auto_index=12 -> index_error=1 from grant, through done, until the next grant; a following index-5 command -> 0.
REQ-033 Boundary: phy_resp_strobe on the terminal-count cycle -> response captured, timeout_error=0.
REQ-034 Reset mid-operation: reset_host=0 during WAIT_RESP -> all outputs 0 asynchronously, no done pulse, and a fresh host request is granted normally after release.

Source files
------------

// File: rtl/cmd_pkg.sv
// cmd_pkg: shared state encoding, frame constants and widths for the command arbiter
package cmd_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RESP, ACK, DONE} state_t;
  localparam logic [1:0] FRAME_START = 2'b01;
  localparam int DEFAULT_ERROR_INDEX = 12;
  localparam int CMD_W = 40;
  localparam int RESP_W = 136;
  localparam int PAYLOAD_W = 128;
  function automatic logic [CMD_W-1:0] make_frame(input logic [5:0] index, input logic [31:0] argument);
    return {FRAME_START, index, argument};
  endfunction
endpackage

// File: rtl/cmd_arbiter_if.sv
// cmd_arbiter_if: requester and physical-layer signals of the command arbiter
interface cmd_arbiter_if;
  import cmd_pkg::*;
  logic req_host, req_auto;
  logic [5:0] host_index, auto_index;
  logic [31:0] host_argument, auto_argument;
  logic grant_host, grant_auto, done_host, done_auto;
  logic [PAYLOAD_W-1:0] resp_out;
  logic index_error, timeout_error, busy;
  logic phy_strobe, phy_ack, phy_resp_strobe, phy_ack_in;
  logic [CMD_W-1:0] phy_cmd;
  logic [RESP_W-1:0] phy_response;
  modport master (
    input req_host, req_auto, host_index, auto_index, host_argument, auto_argument,
    input phy_resp_strobe, phy_response, phy_ack_in,
    output grant_host, grant_auto, done_host, done_auto, resp_out,
    output index_error, timeout_error, busy, phy_strobe, phy_cmd, phy_ack
  );
  modport slave (
    output req_host, req_auto, host_index, auto_index, host_argument, auto_argument,
    output phy_resp_strobe, phy_response, phy_ack_in,
    input grant_host, grant_auto, done_host, done_auto, resp_out,
    input index_error, timeout_error, busy, phy_strobe, phy_cmd, phy_ack
  );
endinterface

// File: rtl/cmd_timeout_counter.sv
// cmd_timeout_counter: 16-bit saturating cycle counter with synchronous clear and terminal-count flag
module cmd_timeout_counter #(
  parameter int TERMINAL = 63
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (en && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign tc = cnt_q == 16'(TERMINAL);
endmodule

// File: rtl/cmd_arbiter.sv
// cmd_arbiter: round-robin arbiter between host and auto command sources, running one
// command at a time through issue, response wait (with timeout), ack and done
module cmd_arbiter
  import cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ERROR_INDEX = DEFAULT_ERROR_INDEX
) (
  input logic clk_host,
  input logic reset_host,
  cmd_arbiter_if.master bus
);
  state_t state_q, state_d;
  logic grant_host_q, grant_host_d, grant_auto_q, grant_auto_d;
  logic done_host_q, done_host_d, done_auto_q, done_auto_d;
  logic index_error_q, index_error_d, timeout_error_q, timeout_error_d;
  logic busy_q, busy_d, phy_strobe_q, phy_strobe_d, phy_ack_q, phy_ack_d;
  logic last_auto_q, last_auto_d;
  logic [CMD_W-1:0] phy_cmd_q, phy_cmd_d;
  logic [PAYLOAD_W-1:0] resp_out_q, resp_out_d;
  logic win_host, tc, unused_resp_lsb;
  logic [5:0] win_index;
  // on a tie the side not served last wins
  assign win_host = bus.req_host && (!bus.req_auto || last_auto_q);
  assign win_index = win_host ? bus.host_index : bus.auto_index;
  assign unused_resp_lsb = ^bus.phy_response[RESP_W-PAYLOAD_W-1:0];
  cmd_timeout_counter #(.TERMINAL(TIMEOUT_CYCLES - 1)) u_timeout (
    .clk(clk_host),
    .rst_n(reset_host),
    .clr(state_q == IDLE),
    .en(state_q == WAIT_RESP),
    .tc(tc)
  );
  always_comb begin
    state_d = state_q;
    grant_host_d = grant_host_q;
    grant_auto_d = grant_auto_q;
    index_error_d = index_error_q;
    timeout_error_d = timeout_error_q;
    last_auto_d = last_auto_q;
    phy_cmd_d = phy_cmd_q;
    resp_out_d = resp_out_q;
    case (state_q)
      IDLE: if (bus.req_host || bus.req_auto) begin
        state_d = ISSUE;
        grant_host_d = win_host;
        grant_auto_d = !win_host;
        phy_cmd_d = make_frame(win_index, win_host ? bus.host_argument : bus.auto_argument);
        index_error_d = win_index == 6'(ERROR_INDEX);
        timeout_error_d = 1'b0;
      end
      ISSUE: state_d = WAIT_RESP;
      // a response on the terminal-count cycle takes priority over the timeout
      WAIT_RESP: if (bus.phy_resp_strobe) begin
        state_d = ACK;
        resp_out_d = bus.phy_response[RESP_W-1:RESP_W-PAYLOAD_W];
      end else if (tc) begin
        state_d = DONE;
        timeout_error_d = 1'b1;
        resp_out_d = '0;
      end
      ACK: if (bus.phy_ack_in) state_d = DONE;
      DONE: begin
        state_d = IDLE;
        grant_host_d = 1'b0;
        grant_auto_d = 1'b0;
        last_auto_d = grant_auto_q;
      end
      default: state_d = IDLE;
    endcase
    phy_strobe_d = state_d == ISSUE || state_d == WAIT_RESP;
    phy_ack_d = state_d == ACK;
    busy_d = state_d != IDLE;
    done_host_d = state_d == DONE && grant_host_q;
    done_auto_d = state_d == DONE && grant_auto_q;
  end
  always_ff @(posedge clk_host or negedge reset_host)
    if (!reset_host) begin
      state_q <= IDLE;
      grant_host_q <= 1'b0;
      grant_auto_q <= 1'b0;
      done_host_q <= 1'b0;
      done_auto_q <= 1'b0;
      index_error_q <= 1'b0;
      timeout_error_q <= 1'b0;
      busy_q <= 1'b0;
      phy_strobe_q <= 1'b0;
      phy_ack_q <= 1'b0;
      last_auto_q <= 1'b1;
      phy_cmd_q <= '0;
      resp_out_q <= '0;
    end else begin
      state_q <= state_d;
      grant_host_q <= grant_host_d;
      grant_auto_q <= grant_auto_d;
      done_host_q <= done_host_d;
      done_auto_q <= done_auto_d;
      index_error_q <= index_error_d;
      timeout_error_q <= timeout_error_d;
      busy_q <= busy_d;
      phy_strobe_q <= phy_strobe_d;
      phy_ack_q <= phy_ack_d;
      last_auto_q <= last_auto_d;
      phy_cmd_q <= phy_cmd_d;
      resp_out_q <= resp_out_d;
    end
  assign bus.grant_host = grant_host_q;
  assign bus.grant_auto = grant_auto_q;
  assign bus.done_host = done_host_q;
  assign bus.done_auto = done_auto_q;
  assign bus.index_error = index_error_q;
  assign bus.timeout_error = timeout_error_q;
  assign bus.busy = busy_q;
  assign bus.phy_strobe = phy_strobe_q;
  assign bus.phy_ack = phy_ack_q;
  assign bus.phy_cmd = phy_cmd_q;
  assign bus.resp_out = resp_out_q;
endmodule

// File: tb/tb_cmd_arbiter.sv
// tb_cmd_arbiter: vector table, reset and randomized transactions for cmd_arbiter
module tb_cmd_arbiter;
  import cmd_pkg::*;
  localparam int TO = 64;
  typedef struct {
    bit rh, ra;
    logic [5:0] hi, ai;
    logic [31:0] ha, aa;
    int rdly, adly;
    logic [127:0] pl;
    bit eh;
    logic [39:0] ecmd;
    bit eierr, eterr;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  bit last_auto_m = 1'b1;
  vec_t tv[8];
  cmd_arbiter_if bus();
  cmd_arbiter #(.TIMEOUT_CYCLES(TO), .ERROR_INDEX(12)) dut (
    .clk_host(clk),
    .reset_host(rst_n),
    .bus(bus.master)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask
  task automatic txn(input vec_t v, input string tag);
    int n;
    bit saw_ack;
    logic [127:0] eresp;
    eresp = v.eterr ? 128'd0 : v.pl;
    @(negedge clk);
    bus.req_host = v.rh;
    bus.req_auto = v.ra;
    bus.host_index = v.hi;
    bus.auto_index = v.ai;
    bus.host_argument = v.ha;
    bus.auto_argument = v.aa;
    n = 0;
    while (!(bus.grant_host || bus.grant_auto) && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " grant_latency"}, 128'(n), 128'd1);
    chk({tag, " grant"}, 128'({bus.grant_host, bus.grant_auto}), 128'({v.eh, !v.eh}));
    chk({tag, " phy_cmd@grant"}, 128'(bus.phy_cmd), 128'(v.ecmd));
    chk({tag, " index_error@grant"}, 128'(bus.index_error), 128'(v.eierr));
    chk({tag, " timeout_error@grant"}, 128'(bus.timeout_error), 128'd0);
    chk({tag, " strobe_busy@grant"}, 128'({bus.phy_strobe, bus.busy}), 128'd3);
    {bus.host_index, bus.auto_index, bus.host_argument, bus.auto_argument} = ~{v.hi, v.ai, v.ha, v.aa};
    @(negedge clk);
    saw_ack = 1'b0;
    n = 0;
    if (v.rdly >= 0) begin
      repeat (v.rdly) begin
        saw_ack |= bus.phy_ack;
        bus.phy_ack_in = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      chk({tag, " strobe_ack@resp"}, 128'({bus.phy_strobe, saw_ack}), 128'd2);
      bus.phy_ack_in = 1'b0;
      bus.phy_resp_strobe = 1'b1;
      bus.phy_response = {v.pl, 8'h3C};
      @(negedge clk);
      bus.phy_resp_strobe = 1'b0;
      bus.phy_response = '1;
      chk({tag, " ack_strobe@ack"}, 128'({bus.phy_ack, bus.phy_strobe}), 128'd2);
      repeat (v.adly) @(negedge clk);
      chk({tag, " ack_held"}, 128'({bus.phy_ack, bus.done_host, bus.done_auto}), 128'd4);
      bus.phy_ack_in = 1'b1;
      @(negedge clk);
      bus.phy_ack_in = 1'b0;
    end else begin
      while (!(bus.done_host || bus.done_auto) && n < 3 * TO) begin
        saw_ack |= bus.phy_ack;
        bus.phy_ack_in = 1'($urandom_range(0, 1));
        @(negedge clk);
        n++;
      end
      bus.phy_ack_in = 1'b0;
      chk({tag, " timeout_cycles"}, 128'(n), 128'(TO));
      chk({tag, " ack_never"}, 128'(saw_ack), 128'd0);
    end
    chk({tag, " done"}, 128'({bus.done_host, bus.done_auto}), 128'({v.eh, !v.eh}));
    chk({tag, " grant@done"}, 128'({bus.grant_host, bus.grant_auto}), 128'({v.eh, !v.eh}));
    chk({tag, " timeout_error@done"}, 128'(bus.timeout_error), 128'(v.eterr));
    chk({tag, " resp_out@done"}, bus.resp_out, eresp);
    chk({tag, " cmd_ierr@done"}, 128'({bus.phy_cmd, bus.index_error}), 128'({v.ecmd, v.eierr}));
    chk({tag, " phy_idle@done"}, 128'({bus.phy_strobe, bus.phy_ack, bus.busy}), 128'd1);
    bus.req_host = 1'b0;
    bus.req_auto = 1'b0;
    @(negedge clk);
    chk({tag, " after_done"}, 128'({bus.done_host, bus.done_auto, bus.grant_host, bus.grant_auto, bus.busy}), 128'd0);
    chk({tag, " hold"}, 128'({bus.phy_cmd, bus.index_error, bus.timeout_error}), 128'({v.ecmd, v.eierr, v.eterr}));
    chk({tag, " resp_hold"}, bus.resp_out, eresp);
    last_auto_m = !v.eh;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int n;
    vec_t r;
    bus.req_host = 1'b1;
    bus.req_auto = 1'b0;
    bus.host_index = '0;
    bus.auto_index = '0;
    bus.host_argument = '0;
    bus.auto_argument = '0;
    bus.phy_resp_strobe = 1'b0;
    bus.phy_response = '0;
    bus.phy_ack_in = 1'b0;
    tv[0] = '{1'b1, 1'b1, 6'd3, 6'd9, 32'h1, 32'hDEAD_BEEF, 0, 0, {16{8'h11}}, 1'b1, 40'h43_0000_0001, 1'b0, 1'b0};
    tv[1] = '{1'b1, 1'b1, 6'd3, 6'd9, 32'h1, 32'hDEAD_BEEF, 1, 0, {16{8'h22}}, 1'b0, 40'h49_DEAD_BEEF, 1'b0, 1'b0};
    tv[2] = '{1'b1, 1'b1, 6'd33, 6'd9, 32'h8000_0000, 32'h5, 2, 1, {16{8'h33}}, 1'b1, 40'h61_8000_0000, 1'b0, 1'b0};
    tv[3] = '{1'b1, 1'b0, 6'd3, 6'd0, 32'h1, 32'h0, 5, 2, {16{8'hA5}}, 1'b1, 40'h43_0000_0001, 1'b0, 1'b0};
    tv[4] = '{1'b0, 1'b1, 6'd0, 6'd12, 32'h0, 32'hFF, 10, 1, {16{8'h5A}}, 1'b0, 40'h4C_0000_00FF, 1'b1, 1'b0};
    tv[5] = '{1'b1, 1'b0, 6'd5, 6'd0, 32'hCAFE_F00D, 32'h0, -1, 0, {16{8'h77}}, 1'b1, 40'h45_CAFE_F00D, 1'b0, 1'b1};
    tv[6] = '{1'b0, 1'b1, 6'd0, 6'd63, 32'h0, 32'hFFFF_FFFF, TO - 1, 3, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0, 40'h7F_FFFF_FFFF, 1'b0, 1'b0};
    tv[7] = '{1'b1, 1'b1, 6'd12, 6'd1, 32'h0, 32'h9, TO - 2, 0, {16{8'hC3}}, 1'b1, 40'h4C_0000_0000, 1'b1, 1'b0};
    repeat (3) @(negedge clk);
    chk("reset flags", 128'({bus.grant_host, bus.grant_auto, bus.done_host, bus.done_auto, bus.index_error, bus.timeout_error, bus.busy, bus.phy_strobe, bus.phy_ack}), 128'd0);
    chk("reset phy_cmd", 128'(bus.phy_cmd), 128'd0);
    chk("reset resp_out", bus.resp_out, 128'd0);
    bus.req_host = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) txn(tv[i], $sformatf("row%0d", i));
    @(negedge clk);
    bus.req_host = 1'b1;
    bus.host_index = 6'd7;
    bus.host_argument = 32'h7;
    n = 0;
    while (!bus.grant_host && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("rst grant_latency", 128'(n), 128'd1);
    repeat (5) @(negedge clk);
    chk("rst busy_before", 128'({bus.busy, bus.phy_strobe}), 128'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst async flags", 128'({bus.grant_host, bus.grant_auto, bus.done_host, bus.done_auto, bus.index_error, bus.timeout_error, bus.busy, bus.phy_strobe, bus.phy_ack}), 128'd0);
    chk("rst async phy_cmd", 128'(bus.phy_cmd), 128'd0);
    chk("rst async resp_out", bus.resp_out, 128'd0);
    bus.req_host = 1'b0;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done_host || bus.done_auto || bus.busy) n++;
    end
    chk("rst no_done", 128'(n), 128'd0);
    rst_n = 1'b1;
    last_auto_m = 1'b1;
    r = '{1'b1, 1'b1, 6'd2, 6'd4, 32'h2, 32'h4, 3, 1, {16{8'h99}}, 1'b1, 40'h42_0000_0002, 1'b0, 1'b0};
    txn(r, "post_reset_tie");
    for (int i = 0; i < 16; i++) begin
      r.rh = 1'($urandom_range(0, 1));
      r.ra = r.rh ? 1'($urandom_range(0, 1)) : 1'b1;
      r.hi = ($urandom_range(0, 3) == 0) ? 6'd12 : 6'($urandom_range(0, 63));
      r.ai = ($urandom_range(0, 3) == 0) ? 6'd12 : 6'($urandom_range(0, 63));
      r.ha = $urandom;
      r.aa = $urandom;
      r.rdly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO - 1));
      r.adly = int'($urandom_range(0, 4));
      r.pl = {$urandom, $urandom, $urandom, $urandom};
      r.eh = (r.rh && r.ra) ? last_auto_m : r.rh;
      r.ecmd = {2'b01, r.eh ? r.hi : r.ai, r.eh ? r.ha : r.aa};
      r.eierr = (r.eh ? r.hi : r.ai) == 6'd12;
      r.eterr = r.rdly < 0;
      txn(r, $sformatf("rand%0d", i));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
